// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter sharing one synchronous single-port SRAM between fetch (I) and load/store (D).
// Define RAM_ARB_RMW_EN to merge partial-byte stores with a read-modify-write (MERGE) cycle.
module ram_arbiter_2p #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   ram_adr,
    output logic [DATA_W-1:0]   ram_d,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_q
);

    logic i_win;
    logic d_win;
    logic busy;
    logic last_d_p0;
    logic i_vld_p1;
    logic d_vld_p1;

`ifdef RAM_ARB_RMW_EN
    localparam int BE_W = DATA_W/8;

    typedef enum logic {IDLE, MERGE} state_t;

    state_t              state_p0;
    state_t              state_nxt;
    logic                rmw_start;
    logic [ADDR_W-1:0]   adr_p1;
    logic [DATA_W-1:0]   wdata_p1;
    logic [BE_W-1:0]     be_p1;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] mask;
        for (int b = 0; b < BE_W; b++) begin
            mask[b*8 +: 8] = {8{be[b]}};
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    assign busy      = (state_p0 == MERGE);
    assign rmw_start = d_win && d_we && (d_be != '0) && (d_be != '1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE:    if (rmw_start) state_nxt = MERGE;
            MERGE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: hold the partial store until the old word comes back on ram_q
    always_ff @(posedge CLK) begin
        if (rmw_start) begin
            adr_p1   <= d_addr;
            wdata_p1 <= d_wdata;
            be_p1    <= d_be;
        end
    end
`else
    assign busy = 1'b0;
`endif

    // p0: combinational arbitration and SRAM drive in the acceptance cycle
    always_comb begin
        i_win   = 1'b0;
        d_win   = 1'b0;
        ram_adr = '0;
        ram_d   = '0;
        ram_we  = 1'b0;
        if (RST_N && !busy) begin
            i_win = i_req && (!d_req || last_d_p0);
            d_win = d_req && (!i_req || !last_d_p0);
        end
        if (i_win) begin
            ram_adr = i_addr;
        end else if (d_win && !d_we) begin
            ram_adr = d_addr;
        end else if (d_win && (d_be != '0)) begin
            ram_adr = d_addr;
`ifdef RAM_ARB_RMW_EN
            if (d_be == '1) begin
                ram_d  = d_wdata;
                ram_we = 1'b1;
            end
`else
            ram_d  = d_wdata;
            ram_we = 1'b1;
`endif
        end
`ifdef RAM_ARB_RMW_EN
        if (RST_N && busy) begin
            ram_adr = adr_p1;
            ram_d   = merge_bytes(ram_q, wdata_p1, be_p1);
            ram_we  = 1'b1;
        end
`endif
    end

    assign i_gnt = i_win;
    assign d_gnt = d_win;

    // p0 -> p1: read tags and round-robin pointer
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_d_p0 <= 1'b1;
            i_vld_p1  <= 1'b0;
            d_vld_p1  <= 1'b0;
        end else begin
            i_vld_p1 <= i_win;
            d_vld_p1 <= d_win && !d_we;
            if (i_win || d_win) begin
                last_d_p0 <= d_win;
            end
        end
    end

    // p1: return registered SRAM data to the tagged port
    assign i_rvalid = i_vld_p1;
    assign d_rvalid = d_vld_p1;
    assign i_rdata  = i_vld_p1 ? ram_q : '0;
    assign d_rdata  = d_vld_p1 ? ram_q : '0;

endmodule

// File: doc/ram_arbiter_2p.md
# ram_arbiter_2p

Two-port arbiter and sequencer for the 16384x32 single-port core SRAM. It shares one synchronous RAM between the instruction-fetch port (I) and the load/store port (D) with round-robin fairness, and returns read data one cycle after grant. It sits between the core's fetch/LSU and the SRAM macro, and drives the macro's CLK-domain address, data and write-enable pins directly.

## Interface
- ADDR_W, 14, word-address width (16384 words)
- DATA_W, 32, data width; byte lanes = DATA_W/8

- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, held until granted
- i_addr  in  ADDR_W  fetch word address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid
- i_rdata  out  DATA_W  fetch data; 0 when i_rvalid low
- d_req  in  1  load/store request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  load/store word address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  load/store accepted this cycle
- d_rvalid  out  1  load data valid (never for stores)
- d_rdata  out  DATA_W  load data; 0 when d_rvalid low
- ram_adr  out  ADDR_W  SRAM address
- ram_d  out  DATA_W  SRAM write data
- ram_we  out  1  SRAM write enable, active high
- ram_q  in  DATA_W  SRAM registered read data, valid one cycle after read

## Operation
- A request is accepted when req && gnt in the same cycle. Fields must be stable while req is high and gnt is low.
- Arbitration is combinational in the acceptance cycle:
  - One requester only: it wins.
  - Both requesting: the port opposite `last` wins; `last` updates on every grant.
  - Only one gnt is high per cycle.
- The winning request drives ram_adr, ram_d and ram_we in the same cycle.
- Loads and fetches: a 1-bit registered tag records the port. The next cycle raises that port's rvalid, and rdata = ram_q.
- States: IDLE (arbitrating) and MERGE (RMW only; see Configuration).
- While in MERGE, both gnt outputs are low.
- With no grant: ram_we=0, and ram_adr/ram_d = 0.
- Stores with d_be==0: accepted, but there is no SRAM access and ram_we=0.
- Reset, asynchronous:
  - State returns to IDLE and `last`=D, so I wins first contention.
  - The rvalid tags are cleared, and any pending RMW is discarded with no write.
  - While RST_N is low, every output is 0: gnt, rvalid, rdata, ram_adr, ram_d, ram_we.

## Timing
- Grant latency: 0 cycles, combinational from req.
- Read latency: rvalid exactly 1 cycle after the grant cycle, high for one cycle.
- Throughput: one access per cycle; back-to-back reads from the same port or from alternating ports sustain one rvalid per cycle.
- A full-word store costs one cycle. A read of the same address in the next cycle returns the new data.
- The ram_q value in the cycle after a store is undefined. No rvalid is raised for it.
- Partial store with RMW: occupies 2 cycles (grant+read, then MERGE+write). The earliest next grant is the cycle after MERGE.
- Round robin: under continuous contention, grants alternate I, D, I, D. A partial store's two cycles count as one D grant.

## Configuration
- RAM_ARB_RMW_EN defined:
  - A store with 0 < d_be < all-ones reads the word in the grant cycle (ram_we=0) and enters MERGE.
  - In MERGE: ram_d = (ram_q & ~mask) | (saved wdata & mask), with the byte mask expanded from saved d_be. ram_adr = saved address, ram_we=1. Then return to IDLE.
  - A store with all-ones d_be is written directly.
- RAM_ARB_RMW_EN undefined:
  - The MERGE state is absent and d_be is ignored except for the ==0 no-op case.
  - Every store with non-zero d_be writes the full d_wdata word in one cycle.

## Test plan
- Reset and idle: reset, then no requests → all outputs 0. Assert RST_N with i_req=1 → i_gnt=1 same cycle, i_rvalid=1 next cycle.
- Single-port read: preload word 0x0005=0xDEADBEEF; i_req, i_addr=5 → i_gnt same cycle, next cycle i_rvalid=1, i_rdata=0xDEADBEEF, d_rvalid=0.
- Contention: i_req and d_req held high for 6 loads → grant order I,D,I,D,I,D. Each rvalid lands on the matching port one cycle later.
- Store then load: D store 0x3FFF←0x12345678 with be=F, then a load of 0x3FFF on the next cycle → d_rdata=0x12345678 one cycle after the load grant. No rvalid for the store.
- RMW (RAM_ARB_RMW_EN defined): word 0x10=0xAABBCCDD; store be=0011, wdata=0x11223344 → 2 busy cycles with i_req blocked; a later read returns 0xAABB3344. Same stimulus without the macro → 0x11223344.
- Reset mid-RMW: drop RST_N during MERGE → ram_we=0 immediately. After reset, word 0x10 is still 0xAABBCCDD.
